complex_addsub_pipe: RTL and testbench

COMPLEX_ADDSUB_PIPE -- requirements
Module: complex_addsub_pipe

---
 rtl/complex_addsub_pipe.sv | 89 ++++++++
 tb/tb_complex_addsub_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/complex_addsub_pipe.sv
// Two-stage pipelined complex adder/subtractor with valid/ready handshake.
// Stage 1 holds the operands; stage 2 holds the per-component result, carry and overflow.
module complex_addsub_pipe #(
   parameter int W   = 16,
   parameter int SAT = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           mode,
   input  logic [2*W-1:0] a,
   input  logic [2*W-1:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] r,
   output logic [1:0]     c_out,
   output logic [1:0]     ovf
);

   logic           v1;
   logic           v2;
   logic [2*W-1:0] a1;
   logic [2*W-1:0] b1;
   logic           mode1;
   logic           en1;
   logic           en2;
   logic [W+1:0]   re_res;
   logic [W+1:0]   im_res;

   // Returns {carry, overflow, result} for one W-bit component
   function automatic logic [W+1:0] addsub(input logic [W-1:0] x,
                                           input logic [W-1:0] bc,
                                           input logic         m);
      logic [W-1:0] y;
      logic [W:0]   sum;
      logic         o;
      logic [W-1:0] res;
      y   = m ? ~bc : bc;
      sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, m};
      o   = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
      res = sum[W-1:0];
      if ((SAT != 0) && o)
         res = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return {sum[W], o, res};
   endfunction

   assign en2       = !v2 || out_ready;
   assign en1       = !v1 || en2;
   assign in_ready  = en1;
   assign out_valid = v2;

   always_comb begin
      re_res = addsub(a1[2*W-1:W], b1[2*W-1:W], mode1);
      im_res = addsub(a1[W-1:0],   b1[W-1:0],   mode1);
   end

   // A stage loads whenever its downstream slot frees up; an empty upstream leaves a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         a1    <= '0;
         b1    <= '0;
         mode1 <= 1'b0;
         r     <= '0;
         c_out <= '0;
         ovf   <= '0;
      end else begin
         if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
               a1    <= a;
               b1    <= b;
               mode1 <= mode;
            end
         end
         if (en2) begin
            v2 <= v1;
            if (v1) begin
               r     <= {re_res[W-1:0], im_res[W-1:0]};
               c_out <= {re_res[W+1], im_res[W+1]};
               ovf   <= {re_res[W], im_res[W]};
            end
         end
      end
   end

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Randomised and directed bench for complex_addsub_pipe; wrap and saturating
// instances share stimulus and are checked against an arithmetic model.
module tb_complex_addsub_pipe;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          mode = 1'b0;
   logic [2*W-1:0] a = '0;
   logic [2*W-1:0] b = '0;
   logic          out_ready = 1'b0;
   logic          in_ready_w, in_ready_s;
   logic          out_valid_w, out_valid_s;
   logic [2*W-1:0] r_w, r_s;
   logic [1:0]    c_w, c_s, o_w, o_s;

   typedef struct {
      logic [31:0] r_wrap;
      logic [31:0] r_sat;
      logic [1:0]  c;
      logic [1:0]  o;
      int          accept_edge;
   } exp_t;

   exp_t q[$];
   int   edge_count = 0;
   int   check_count = 0;
   int   pass_count = 0;

   complex_addsub_pipe #(.W(W), .SAT(0)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .mode(mode), .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
      .r(r_w), .c_out(c_w), .ovf(o_w)
   );

   complex_addsub_pipe #(.W(W), .SAT(1)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .mode(mode), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
      .r(r_s), .c_out(c_s), .ovf(o_s)
   );

   always #5 clk = ~clk;

   // True signed/unsigned arithmetic on one component, then wrap or clamp
   function automatic void model_half(input logic [15:0] x, input logic [15:0] y, input logic m,
                                      output logic [15:0] wrap, output logic [15:0] sat,
                                      output logic c, output logic o);
      longint sx, sy, t, ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'(x);
      uy = longint'(y);
      t  = m ? sx - sy : sx + sy;
      o  = (t > 32767) || (t < -32768);
      c  = m ? (ux >= uy) : ((ux + uy) > 65535);
      wrap = t[15:0];
      sat  = !o ? wrap : ((t > 0) ? 16'h7FFF : 16'h8000);
   endfunction

   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic m);
      exp_t e;
      logic [15:0] w_re, s_re, w_im, s_im;
      logic c_re, o_re, c_im, o_im;
      model_half(av[31:16], bv[31:16], m, w_re, s_re, c_re, o_re);
      model_half(av[15:0],  bv[15:0],  m, w_im, s_im, c_im, o_im);
      e.r_wrap = {w_re, w_im};
      e.r_sat  = {s_re, s_im};
      e.c      = {c_re, c_im};
      e.o      = {o_re, o_im};
      e.accept_edge = edge_count + 1;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drive one cycle from a negedge, check everything observable, predict transfers
   task automatic applyStimulus(input logic iv, input logic md, input logic [31:0] av,
                                input logic [31:0] bv, input logic ordy);
      logic exp_valid;
      in_valid = iv; mode = md; a = av; b = bv; out_ready = ordy;
      #1;
      exp_valid = (q.size() > 0) && (edge_count >= q[0].accept_edge + 1);
      checkOutput("in_ready_wrap", 32'(in_ready_w), 32'(!(q.size() == 2 && !ordy)));
      checkOutput("in_ready_sat",  32'(in_ready_s), 32'(!(q.size() == 2 && !ordy)));
      checkOutput("out_valid_wrap", 32'(out_valid_w), 32'(exp_valid));
      checkOutput("out_valid_sat",  32'(out_valid_s), 32'(exp_valid));
      if (exp_valid) begin
         checkOutput("r_wrap", r_w, q[0].r_wrap);
         checkOutput("r_sat",  r_s, q[0].r_sat);
         checkOutput("c_out_wrap", 32'(c_w), 32'(q[0].c));
         checkOutput("c_out_sat",  32'(c_s), 32'(q[0].c));
         checkOutput("ovf_wrap", 32'(o_w), 32'(q[0].o));
         checkOutput("ovf_sat",  32'(o_s), 32'(q[0].o));
         if (ordy) void'(q.pop_front());
      end
      if (iv && !(q.size() == 2 && !ordy)) q.push_back(model(av, bv, md));
      @(negedge clk);
      edge_count++;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_valid"}, {30'd0, out_valid_w, out_valid_s}, 32'd0);
      checkOutput({tag, "_r_wrap"}, r_w, 32'd0);
      checkOutput({tag, "_r_sat"},  r_s, 32'd0);
      checkOutput({tag, "_flags"}, {24'd0, c_w, c_s, o_w, o_s}, 32'd0);
   endtask

   function automatic logic [15:0] rand_comp();
      case ($urandom_range(0, 5))
         0:       return 16'h7FFF;
         1:       return 16'h8000;
         2:       return 16'h0001;
         3:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      // Power-up reset, with in_valid asserted to show it is ignored
      in_valid = 1'b1;
      a = 32'h0003_0005;
      #1;
      checkReset("reset_async");
      @(negedge clk);
      @(negedge clk);
      checkReset("reset_held");
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("in_ready_after_reset", 32'(in_ready_w), 32'd1);

      // Directed arithmetic cases, full throughput
      applyStimulus(1, 0, 32'h0003_0005, 32'h0001_0002, 1);
      applyStimulus(1, 1, 32'h0003_0005, 32'h0001_0007, 1);
      applyStimulus(1, 0, 32'h7FFF_0000, 32'h0001_0000, 1);
      applyStimulus(1, 1, 32'h8000_0000, 32'h0001_0000, 1);
      applyStimulus(1, 1, 32'h0000_8000, 32'h8000_0001, 1);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 32'd0, 32'd0, 1);

      // Back-to-back inputs against a four-cycle downstream stall
      applyStimulus(1, 0, 32'h1111_2222, 32'h0101_0202, 0);
      applyStimulus(1, 1, 32'h3333_4444, 32'h0303_0404, 0);
      applyStimulus(1, 0, 32'h5555_6666, 32'h0505_0606, 0);
      checkOutput("stall_in_ready", 32'(in_ready_w), 32'd0);
      applyStimulus(1, 0, 32'h5555_6666, 32'h0505_0606, 0);
      for (int k = 0; k < 5; k++) applyStimulus(0, 0, 32'd0, 32'd0, 1);

      // Random traffic with random backpressure
      for (int k = 0; k < 300; k++)
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom),
                       {rand_comp(), rand_comp()}, {rand_comp(), rand_comp()},
                       1'($urandom_range(0, 2) != 0));

      // Fill both stages, then reset asynchronously between edges
      applyStimulus(1, 0, 32'h0102_0304, 32'h0001_0001, 0);
      applyStimulus(1, 0, 32'h0506_0708, 32'h0001_0001, 0);
      applyStimulus(0, 0, 32'd0, 32'd0, 0);
      #2;
      rst = 1'b1;
      #1;
      checkReset("reset_midflight");
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("in_ready_after_midreset", 32'(in_ready_w), 32'd1);
      applyStimulus(1, 1, 32'h0010_0020, 32'h0030_0005, 1);
      for (int k = 0; k < 20 && q.size() > 0; k++) applyStimulus(0, 0, 32'd0, 32'd0, 1);
      checkOutput("drain_outstanding", 32'(q.size()), 32'd0);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
